// File: rtl/axi_slave_mem_sched_if.sv
// Slave-side request/response bundle between the AXI translation layer and the memory scheduler.
// The master modport drives strobes; the slave modport returns read data and throttling.
interface axi_slave_mem_sched_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int STRB_WIDTH     = AXI_DATA_WIDTH/8
);
  logic                      write_valid;
  logic [AXI_DATA_WIDTH-1:0] write_data;
  logic [STRB_WIDTH-1:0]     write_strb;
  logic [AXI_ADDR_WIDTH-1:0] w_opt_addr;
  logic                      read_req;
  logic [AXI_ADDR_WIDTH-1:0] r_opt_addr;
  logic [AXI_DATA_WIDTH-1:0] read_data;
  logic                      read_valid;
  logic                      aw_ar_ready;

  modport master (
    output write_valid, write_data, write_strb, w_opt_addr, read_req, r_opt_addr,
    input  read_data, read_valid, aw_ar_ready
  );

  modport slave (
    input  write_valid, write_data, write_strb, w_opt_addr, read_req, r_opt_addr,
    output read_data, read_valid, aw_ar_ready
  );
endinterface

// File: rtl/axi_slave_mem_sched.sv
// Single-port SRAM scheduler: holds one write and one read, issues one op per cycle.
// Define MEM_SCHED_RR_EN for round-robin tie-breaking; otherwise the write always wins.
module axi_slave_mem_sched #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int STRB_WIDTH     = AXI_DATA_WIDTH/8,
  parameter int MEM_DEPTH      = 16,
  parameter int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int ADDR_LSB       = $clog2(AXI_DATA_WIDTH/8)
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_slave_mem_sched_if.slave      bus,
  output logic                      mem_en,
  output logic [STRB_WIDTH-1:0]     mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [AXI_DATA_WIDTH-1:0] mem_wdata,
  input  logic [AXI_DATA_WIDTH-1:0] mem_rdata
);
  logic                      wr_pend;
  logic                      rd_pend;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr;
  logic [AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0]     wr_strb;
  logic                      rd_s1;
  logic                      rd_s1_oor;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
  logic [AXI_DATA_WIDTH-1:0] mem_wdata_q;

  logic                      ready;
  logic                      accept_w;
  logic                      accept_r;
  logic                      grant_w;
  logic                      issue_w;
  logic                      issue_r;
  logic [AXI_ADDR_WIDTH-1:0] wr_word;
  logic [AXI_ADDR_WIDTH-1:0] rd_word;
  logic                      wr_in_range;
  logic                      rd_in_range;

  assign ready           = !wr_pend && !rd_pend;
  assign bus.aw_ar_ready = ready;
  assign accept_w        = bus.write_valid && ready;
  assign accept_r        = bus.read_req && ready;

`ifdef MEM_SCHED_RR_EN
  // Pointer records the last issued op type; drops count as issues.
  logic last_rd;

  always_ff @(posedge clk) begin
    if (rst)          last_rd <= 1'b1;
    else if (issue_w) last_rd <= 1'b0;
    else if (issue_r) last_rd <= 1'b1;
  end

  assign grant_w = last_rd;
`else
  assign grant_w = 1'b1;
`endif

  assign issue_w     = wr_pend && (!rd_pend || grant_w);
  assign issue_r     = rd_pend && !issue_w;
  assign wr_word     = wr_addr >> ADDR_LSB;
  assign rd_word     = rd_addr >> ADDR_LSB;
  assign wr_in_range = wr_word < AXI_ADDR_WIDTH'(MEM_DEPTH);
  assign rd_in_range = rd_word < AXI_ADDR_WIDTH'(MEM_DEPTH);

  // Address and data buses hold their last driven value while idle or dropping.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if (issue_w && wr_in_range) begin
      mem_en    = 1'b1;
      mem_we    = wr_strb;
      mem_addr  = MEM_ADDR_WIDTH'(wr_word);
      mem_wdata = wr_data;
    end else if (issue_r && rd_in_range) begin
      mem_en   = 1'b1;
      mem_addr = MEM_ADDR_WIDTH'(rd_word);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pend        <= 1'b0;
      rd_pend        <= 1'b0;
      wr_addr        <= '0;
      rd_addr        <= '0;
      wr_data        <= '0;
      wr_strb        <= '0;
      rd_s1          <= 1'b0;
      rd_s1_oor      <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      bus.read_valid <= 1'b0;
      bus.read_data  <= '0;
    end else begin
      if (accept_w) begin
        wr_pend <= 1'b1;
        wr_addr <= bus.w_opt_addr;
        wr_data <= bus.write_data;
        wr_strb <= bus.write_strb;
      end else if (issue_w) begin
        wr_pend <= 1'b0;
      end
      if (accept_r) begin
        rd_pend <= 1'b1;
        rd_addr <= bus.r_opt_addr;
      end else if (issue_r) begin
        rd_pend <= 1'b0;
      end
      // Out-of-range reads still walk the pipeline so the pulse timing matches.
      rd_s1          <= issue_r;
      rd_s1_oor      <= !rd_in_range;
      bus.read_valid <= rd_s1;
      if (rd_s1) bus.read_data <= rd_s1_oor ? '0 : mem_rdata;
      mem_addr_q     <= mem_addr;
      mem_wdata_q    <= mem_wdata;
    end
  end
endmodule
